// File: rtl/lc4_decode_stage.sv
`timescale 1ns/1ps
// lc4_decode_stage: registered instruction-decode stage for the ECC datapath core.
// It decodes one instruction per cycle and keeps a per-register scoreboard of
// destination writes that are still in flight. An instruction that reads or
// writes a pending register is held back (RAW/WAW). Writeback clears scoreboard
// bits, and a flush drops the instruction held in the output register.
module lc4_decode_stage #(
  parameter int INSN_W      = 20,  // must be >= 3*REG_W + 5
  parameter int REG_W       = 5,
  parameter int LINK_REG    = 7,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSN_W-1:0]      in_insn,
  input  logic                   wb_valid,
  input  logic [REG_W-1:0]       wb_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSN_W-1:0]      out_insn,
  output logic [REG_W-1:0]       out_r1sel,
  output logic                   out_r1re,
  output logic [REG_W-1:0]       out_r2sel,
  output logic                   out_r2re,
  output logic [REG_W-1:0]       out_wsel,
  output logic                   out_regfile_we,
  output logic                   out_nzp_we,
  output logic                   out_sel_pc1,
  output logic                   out_is_branch,
  output logic                   out_is_ctrl,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int NREG = 2 ** REG_W;

  localparam logic [4:0] OP_ADD  = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd7;
  localparam logic [4:0] OP_JSR  = 5'd8;
  localparam logic [4:0] OP_ANDI = 5'd9;
  localparam logic [4:0] OP_RTI  = 5'd10;
  localparam logic [4:0] OP_CONST = 5'd11;
  localparam logic [4:0] OP_SLL  = 5'd12;
  localparam logic [4:0] OP_SRL  = 5'd13;
  localparam logic [4:0] OP_SDRH = 5'd14;
  localparam logic [4:0] OP_SDRL = 5'd15;
  localparam logic [4:0] OP_CHK  = 5'd16;
  localparam logic [4:0] OP_LAST_BRANCH = 5'd4;

  // Everything the execute stage needs about one instruction.
  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [REG_W-1:0]  r1sel;
    logic              r1re;
    logic [REG_W-1:0]  r2sel;
    logic              r2re;
    logic [REG_W-1:0]  wsel;
    logic              regfile_we;
    logic              nzp_we;
    logic              sel_pc1;
    logic              is_branch;
    logic              is_ctrl;
    logic              illegal;
  } dec_t;

  // Pure combinational decode of one instruction word.
  function automatic dec_t decode(input logic [INSN_W-1:0] insn);
    dec_t       d;
    logic [4:0] op;
    op      = insn[INSN_W-1 -: 5];
    d       = '0;
    d.insn  = insn;
    d.r1sel = insn[2*REG_W-1 -: REG_W];
    d.r2sel = insn[REG_W-1:0];
    d.wsel  = insn[3*REG_W-1 -: REG_W];
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SDRH, OP_SDRL: begin
        d.r1re = 1'b1;
        d.r2re = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_CHK: d.r1re = 1'b1;
      default: ;
    endcase
    d.nzp_we     = d.r1re | (op == OP_JSR) | (op == OP_CONST);
    d.regfile_we = d.nzp_we & (op != OP_CHK);
    if (op == OP_JSR) begin
      d.wsel    = REG_W'(LINK_REG);
      d.sel_pc1 = 1'b1;
    end
    d.is_branch = (op <= OP_LAST_BRANCH);
    d.is_ctrl   = (op == OP_JSR) | (op == OP_RTI);
    d.illegal   = (op > OP_CHK);
    return d;
  endfunction

  dec_t                   dec_in;
  dec_t                   out_d, out_q;
  logic                   out_valid_d, out_valid_q;
  logic [NREG-1:0]        pend_d, pend_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] eff;
  logic            hazard;
  logic            accept;
  logic            transfer;
  logic            drop;

  // Hazard check of the incoming instruction against the scoreboard, with a
  // same-cycle writeback already taken into account.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    dec_in = decode(in_insn);
    wb_clr = '0;
    if (wb_valid) wb_clr[wb_sel] = 1'b1;
    eff    = pend_q & ~wb_clr;
    hazard = (dec_in.r1re & eff[dec_in.r1sel]) |
             (dec_in.r2re & eff[dec_in.r2sel]) |
             (dec_in.regfile_we & eff[dec_in.wsel]);
    in_ready = ~flush & ~hazard & (~out_valid_q | out_ready);
    accept   = in_valid & in_ready;
    transfer = out_valid_q & out_ready;
    drop     = flush & out_valid_q & ~out_ready;
  end

  // Next-state for the output register, the scoreboard and the stall counter.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pend_d      = eff;
    stall_cnt_d = stall_cnt_q;

    if (accept) begin
      out_d       = dec_in;
      out_valid_d = 1'b1;
    end else if (transfer || drop) begin
      out_valid_d = 1'b0;
    end

    // A dropped instruction never reaches writeback, so release its destination.
    if (drop && out_q.regfile_we) pend_d[out_q.wsel] = 1'b0;
    // Applied last so a new reservation beats a same-cycle writeback of that register.
    if (accept && dec_in.regfile_we) pend_d[dec_in.wsel] = 1'b1;

    if (in_valid && hazard && !flush && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  // State registers; reset clears everything, including the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      // NOTE: the scoreboard is a flop vector rather than a RAM, so it can (and must) take the async reset.
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_insn       = out_q.insn;
  assign out_r1sel      = out_q.r1sel;
  assign out_r1re       = out_q.r1re;
  assign out_r2sel      = out_q.r2sel;
  assign out_r2re       = out_q.r2re;
  assign out_wsel       = out_q.wsel;
  assign out_regfile_we = out_q.regfile_we;
  assign out_nzp_we     = out_q.nzp_we;
  assign out_sel_pc1    = out_q.sel_pc1;
  assign out_is_branch  = out_q.is_branch;
  assign out_is_ctrl    = out_q.is_ctrl;
  assign out_illegal    = out_q.illegal;
  assign stall_cnt      = stall_cnt_q;

endmodule
